// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit feeding the HI/LO pair (one HI+LO write per op).
// Optional MADD/MSUB accumulate ops are built only when MULDIV_MADD_EN is defined.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    input  logic [31:0] hi_rdata,
    input  logic [31:0] lo_rdata,
    output logic        busy,
    output logic        hi_wr,
    output logic        lo_wr,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, FIX, WB} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
`ifdef MULDIV_MADD_EN
    logic [63:0] prod_q, prod_d;
`endif

    logic        op_ok;
    logic        sgn;
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] opa_mag_in, dvs_mag;
    logic [32:0] trial;
    logic        q_neg, r_neg;

`ifdef MULDIV_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op[2];
    logic unused_acc;
    assign unused_acc = ^{hi_rdata, lo_rdata, op_q[2]};
`endif

    // op[0] clear selects the signed flavour for every opcode
    assign sgn     = ~op_q[0];
    assign a_ext   = {{32{sgn & opa_q[31]}}, opa_q};
    assign b_ext   = {{32{sgn & opb_q[31]}}, opb_q};
    assign product = a_ext * b_ext;

    assign opa_mag_in = (~op[0] & opa[31]) ? -opa : opa;
    assign dvs_mag    = (sgn & opb_q[31]) ? -opb_q : opb_q;
    assign trial      = {rem_q, quo_q[31]} - {1'b0, dvs_mag};
    assign q_neg      = sgn & (opa_q[31] ^ opb_q[31]);
    assign r_neg      = sgn & opa_q[31];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_MADD_EN
        prod_d  = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !cancel && op_ok) begin
                    op_d  = op;
                    opa_d = opa;
                    opb_d = opb;
                    if (op[2:1] == 2'b01) begin
                        state_d = DIV;
                        cnt_d   = 5'd31;
                        rem_d   = '0;
                        quo_d   = opa_mag_in;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
`ifdef MULDIV_MADD_EN
                    prod_d = product;
                    if (op_q[2]) begin
                        state_d = ACC;
                    end else begin
                        {hi_d, lo_d} = product;
                        state_d      = WB;
                    end
`else
                    {hi_d, lo_d} = product;
                    state_d      = WB;
`endif
                end
            end
`ifdef MULDIV_MADD_EN
            ACC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[1]) {hi_d, lo_d} = {hi_rdata, lo_rdata} - prod_q;
                    else         {hi_d, lo_d} = {hi_rdata, lo_rdata} + prod_q;
                    state_d = WB;
                end
            end
`endif
            DIV: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    // restoring step: quo_q shifts dividend bits out and quotient bits in
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[30:0], quo_q[31]};
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == 5'd0) state_d = FIX;
                    else               cnt_d   = cnt_q - 5'd1;
                end
            end
            FIX: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (opb_q == 32'd0) begin
                        lo_d = '1;
                        hi_d = opa_q;
                    end else begin
                        lo_d = q_neg ? -quo_q : quo_q;
                        hi_d = r_neg ? -rem_q : rem_q;
                    end
                    state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_MADD_EN
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_MADD_EN
            prod_q  <= prod_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign hi_wr    = (state_q == WB) && !cancel;
    assign lo_wr    = (state_q == WB) && !cancel;
    assign hi_wdata = hi_q;
    assign lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, cancel/reset aborts, ignored starts.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] OP_MSUBU = 3'b111;
`endif

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [2:0]  op;
    logic [31:0] opa, opb, hi_rdata, lo_rdata;
    logic        busy, hi_wr, lo_wr;
    logic [31:0] hi_wdata, lo_wdata;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .cancel   (cancel),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata),
        .busy     (busy),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a falling edge; start is seen by the next rising edge (cycle T).
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        opa   = 32'hDEAD_BEEF;
        opb   = 32'h0BAD_F00D;
    endtask

    // Expects strobes exactly in cycle T+n; optionally pulses start at cycle T+glitch.
    task automatic wait_result(input string tag, input int unsigned n,
                               input logic [31:0] eh, input logic [31:0] el,
                               input int unsigned glitch);
        int unsigned early = 0;
        for (int unsigned k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, ".busy"}, {31'b0, busy}, 32'd1);
            if (glitch != 0 && k == glitch) begin
                start = 1'b1;
                op    = OP_MULT;
                opa   = 32'd3;
                opb   = 32'd3;
            end
            if (glitch != 0 && k == glitch + 1) start = 1'b0;
            if (k < n) begin
                if (hi_wr || lo_wr) early++;
            end else begin
                check({tag, ".strobe"}, {30'b0, hi_wr, lo_wr}, 32'd3);
                check({tag, ".hi"}, hi_wdata, eh);
                check({tag, ".lo"}, lo_wdata, el);
            end
        end
        check({tag, ".early"}, early, 32'd0);
        @(negedge clk);
        check({tag, ".after"}, {30'b0, busy, hi_wr}, 32'd0);
        check({tag, ".hold"}, {hi_wdata ^ eh} | {lo_wdata ^ el}, 32'd0);
        last_hi = eh;
        last_lo = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        rst      = 1'b1;
        start    = 1'b0;
        cancel   = 1'b0;
        op       = '0;
        opa      = '0;
        opb      = '0;
        hi_rdata = 32'd0;
        lo_rdata = 32'd10;
        repeat (3) @(negedge clk);
        check("rst.flags", {29'b0, busy, hi_wr, lo_wr}, 32'd0);
        check("rst.hi", hi_wdata, 32'd0);
        check("rst.lo", lo_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back: each launch happens in the idle cycle after the previous WB
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_result("mult", 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        launch(OP_MULTU, 32'hFFFF_FFFD, 32'd5);
        wait_result("multu", 2, 32'h0000_0004, 32'hFFFF_FFF1, 0);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 2, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mult_m1", 2, 32'h0000_0000, 32'h0000_0001, 0);

        launch(OP_DIVU, 32'd100, 32'd7);
        wait_result("divu", 34, 32'd2, 32'd14, 0);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_result("div_negdvs", 34, 32'd1, 32'hFFFF_FFFD, 0);
        launch(OP_DIVU, 32'h0000_1234, 32'd0);
        wait_result("divu_z", 34, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        launch(OP_DIV, 32'hFFFF_FF00, 32'd0);
        wait_result("div_z", 34, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 34, 32'd0, 32'h8000_0000, 0);

        launch(OP_DIVU, 32'd100, 32'd7);
        wait_result("div_glitch", 34, 32'd2, 32'd14, 5);

`ifdef MULDIV_MADD_EN
        launch(OP_MADD, 32'd3, 32'd4);
        wait_result("madd", 3, 32'd0, 32'd22, 0);
        launch(OP_MSUBU, 32'd1, 32'd11);
        wait_result("msubu", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`else
        launch(OP_MADD, 32'd3, 32'd4);
        cnt = 0;
        for (int unsigned k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (busy || hi_wr || lo_wr) cnt++;
        end
        check("madd_off.act", cnt, 32'd0);
        check("madd_off.hold", lo_wdata, last_lo);
`endif

        // cancel during DIV in cycle T+10
        @(negedge clk);
        launch(OP_DIVU, 32'd200, 32'd9);
        cnt = 0;
        for (int unsigned k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (hi_wr || lo_wr) cnt++;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel.busy", {31'b0, busy}, 32'd0);
        check("cancel.strobe", cnt + {31'b0, hi_wr}, 32'd0);
        check("cancel.hold", hi_wdata, last_hi);
        @(negedge clk);
        launch(OP_MULTU, 32'd6, 32'd7);
        wait_result("after_cancel", 2, 32'd0, 32'd42, 0);

        // cancel in WB kills the strobes combinationally
        launch(OP_MULT, 32'd2, 32'd3);
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        #1;
        check("cancel_wb.strobe", {30'b0, hi_wr, lo_wr}, 32'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_wb.busy", {31'b0, busy}, 32'd0);

        // reset asserted in T+5 of a DIV
        launch(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.flags", {29'b0, busy, hi_wr, lo_wr}, 32'd0);
        check("rst_mid.data", hi_wdata | lo_wdata, 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int unsigned k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy || hi_wr || lo_wr) cnt++;
        end
        check("rst_mid.quiet", cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS32 pipeline, sitting directly upstream of the HI/LO register pair. It accepts one MULT/MULTU/DIV/DIVU operation (plus MADD/MSUB variants when configured) from the EX stage and holds `busy` while it computes. On completion it issues a single-cycle write of both HI and LO with the result. The pipeline stalls any HI/LO-dependent instruction on `busy`.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- opa  in  32  rs operand (multiplicand / dividend)
- opb  in  32  rt operand (multiplier / divisor)
- cancel  in  1  pipeline flush; aborts the operation in flight
- hi_rdata  in  32  current HI value (accumulate ops)
- lo_rdata  in  32  current LO value (accumulate ops)
- busy  out  1  high whenever state ≠ IDLE
- hi_wr  out  1  HI write strobe
- lo_wr  out  1  LO write strobe
- hi_wdata  out  32  HI result (product[63:32] / remainder)
- lo_wdata  out  32  LO result (product[31:0] / quotient)

## Operation
- States: IDLE, MUL, ACC, DIV, FIX, WB.
- IDLE: if `start && !cancel`, latch `op`, `opa`, `opb`. Go to MUL for op 0x0/0x1/1xx, DIV for 01x.
- MUL: registered 64-bit product of the latched operands. Signed for MULT/MADD/MSUB, unsigned otherwise. Next state: ACC for 1xx, else WB.
- ACC: {HI,LO} ← {hi_rdata,lo_rdata} ± product, modulo 2^64. Next state: WB.
- DIV: radix-2 restoring divide on magnitudes (signed ops take absolute values), one quotient bit per cycle, 5-bit counter from 31 down to 0. Exits to FIX after 32 cycles.
- FIX: negate the quotient if the operand signs differ (signed ops only); the remainder takes the sign of the dividend. Next state: WB.
- WB: `hi_wr = lo_wr = (state==WB) && !cancel`. Data comes from the result registers. Next state: IDLE.
- Divide by zero (any div op): lo_wdata = 0xFFFFFFFF, hi_wdata = opa unchanged, full latency preserved.
- Signed DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- `start` while busy is ignored and does not queue.
- `cancel` in any non-IDLE state returns to IDLE at the next edge with no write. `cancel` in WB suppresses the strobes that same cycle.
- Reset: state IDLE, counter 0, result registers 0. All outputs read 0 (busy, hi_wr, lo_wr, hi_wdata, lo_wdata). Reset mid-operation discards it with no write.

## Timing
- Cycle T is the cycle in which `start` is high in IDLE; `busy` rises in T+1.
- MULT/MULTU: strobes in T+2; HI/LO updated at the end of T+2.
- MADD/MSUB family: ACC in T+2 (hi_rdata/lo_rdata sampled then); strobes in T+3.
- DIV/DIVU: DIV in T+1..T+32, FIX in T+33, strobes in T+34.
- `busy` falls in the cycle after WB. A new `start` is accepted in that same cycle, giving back-to-back ops with one idle cycle.
- hi_wdata/lo_wdata are held stable from WB until the next result is produced.

## Configuration
- `MULDIV_MADD_EN` defined: ACC state and ops 1xx are enabled as described.
- Undefined: ACC is not built. `start` with op[2]=1 is ignored: no state change, no `busy`, no write. hi_rdata/lo_rdata remain as ports but are unused.

## Test plan
- MULT opa=0xFFFFFFFD (−3), opb=5 → strobes at T+2, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 → strobes at T+34, lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234 at T+34. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- With the macro: hi_rdata=0, lo_rdata=10, MADD 3×4 → lo=22, hi=0 at T+3. MSUBU 1×11 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- DIV with `cancel` at T+10 → no strobe, busy=0 at T+11. A second `start` at T+12 executes normally. Reset asserted at T+5 → no write, all outputs 0.
- `start` pulsed during an active DIV → ignored, and the single original result appears at T+34. Without the macro, MADD start → busy stays 0.
